// File: rtl/pipeline_pkg.sv
// Shared sizing helpers for the valid/ready upsizer.
// Lane-index width and idle-counter width are derived here so top and timer agree.
package pipeline_pkg;

    function automatic int lane_idx_w(input int ratio);
        return $clog2(ratio);
    endfunction

    function automatic int idle_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/upsize_vr_flush_timer.sv
// Idle counter for a partially assembled word; raises fire when the word should be flushed.
// Only instantiated when UPSIZE_VR_FLUSH_EN is defined.
module upsize_vr_flush_timer
    import pipeline_pkg::*;
#(
    parameter int P_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic accept,
    input  logic slot_free,
    output logic fire
);

    localparam int CW = idle_cnt_w(P_TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(P_TIMEOUT);

    logic [CW-1:0] idle_cnt;

    // An accepted beat always wins over a pending timeout.
    assign fire = active && !accept && slot_free && (idle_cnt == LIMIT);

    // Saturates at LIMIT while the output slot is stalled, so the flush fires once it frees.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!active || accept || fire) begin
            idle_cnt <= '0;
        end else if (idle_cnt != LIMIT) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/upsize_vr.sv
// Valid/ready width upsizer: packs P_RATIO narrow beats into one registered wide word.
// Optional partial-word timeout flush is enabled by defining UPSIZE_VR_FLUSH_EN.
module upsize_vr
    import pipeline_pkg::*;
#(
    parameter int P_IN_WIDTH = 8,
    parameter int P_RATIO    = 4,
    parameter int P_TIMEOUT  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic [P_IN_WIDTH-1:0]         data_in,
    input  logic                          last_in,
    output logic                          ready_in,
    output logic                          valid_out,
    output logic [P_IN_WIDTH*P_RATIO-1:0] data_out,
    output logic [P_RATIO-1:0]            keep_out,
    output logic                          last_out,
    input  logic                          ready_out
);

    localparam int LW = lane_idx_w(P_RATIO);
    localparam int DW = P_IN_WIDTH * P_RATIO;
    localparam logic [LW-1:0] LAST_LANE = LW'(P_RATIO - 1);

    if (P_RATIO < 2) begin : g_bad_ratio
        $error("upsize_vr: P_RATIO must be at least 2");
    end
    if (P_TIMEOUT < 1) begin : g_bad_timeout
        $error("upsize_vr: P_TIMEOUT must be at least 1");
    end

    logic [LW-1:0]      cnt;
    logic [DW-1:0]      asm_data;
    logic [P_RATIO-1:0] asm_keep;
    logic [DW-1:0]      word_next;
    logic [P_RATIO-1:0] keep_next;
    logic               accept;
    logic               complete;
    logic               flush_fire;
    logic               load;

    // Handshake: a beat moves on valid_in && ready_in, a word moves on valid_out && ready_out.
    // ready_in depends only on the output register and ready_out, never on valid_in/last_in.
    assign ready_in = !valid_out || ready_out;
    assign accept   = valid_in && ready_in;
    assign complete = accept && ((cnt == LAST_LANE) || last_in);
    assign load     = complete || flush_fire;

    always_comb begin
        word_next = asm_data;
        keep_next = asm_keep;
        if (accept) begin
            word_next[cnt*P_IN_WIDTH +: P_IN_WIDTH] = data_in;
            keep_next[cnt]                          = 1'b1;
        end
    end

`ifdef UPSIZE_VR_FLUSH_EN
    upsize_vr_flush_timer #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_flush_timer (
        .clk       (clk),
        .rst       (rst),
        .active    (cnt != '0),
        .accept    (accept),
        .slot_free (ready_in),
        .fire      (flush_fire)
    );
`else
    assign flush_fire = 1'b0;
`endif

    // Assembly side: cleared on the same edge its contents move to the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            asm_data <= '0;
            asm_keep <= '0;
        end else if (load) begin
            cnt      <= '0;
            asm_data <= '0;
            asm_keep <= '0;
        end else if (accept) begin
            cnt      <= cnt + 1'b1;
            asm_data <= word_next;
            asm_keep <= keep_next;
        end
    end

    // Output register: a new word may load on the same edge the previous one transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= word_next;
            keep_out  <= keep_next;
            last_out  <= complete && last_in;
        end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_upsize_vr.sv
// Directed bench for upsize_vr: expected words are queued by the stimulus and popped by a monitor.
// Define UPSIZE_VR_FLUSH_EN for both bench and RTL to include the timeout-flush case.
module tb_upsize_vr;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int DW = W * R;
    localparam int EW = 1 + R + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [W-1:0]  data_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [R-1:0]  keep_out;
    logic          last_out;
    logic          ready_out;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [EW-1:0] exp_q[$];
    int            xfer_cyc[$];

    upsize_vr #(
        .P_IN_WIDTH (W),
        .P_RATIO    (R),
        .P_TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out),
        .ready_out (ready_out)
    );

    // Clock / cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic l, input logic [R-1:0] k, input logic [DW-1:0] d);
        exp_q.push_back({l, k, d});
    endtask

    // Drivers run in the phase just after a rising edge.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        logic r;
        int   guard;
        guard    = 0;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        do begin
            @(negedge clk);
            r = ready_in;
            @(posedge clk);
            #1;
            guard++;
        end while (!r && guard < 200);
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: got ready_in=0 want 1 within 200 cycles");
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        last_in  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            xfer_cyc.push_back(cycle);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_unexpected: got %h want no word", {last_out, keep_out, data_out});
            end else begin
                check("word", {last_out, keep_out, data_out}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int waited;
        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        last_in   = 1'b0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_keep_out", keep_out, 0);
        check("rst_last_out", last_out, 0);
        check("rst_ready_in", ready_in, 1);
        rst = 1'b0;
        idle(1);

        // Full packing
        push_exp(1'b1, 4'b1111, 32'h44332211);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b1);
        check("latency_valid", valid_out, 1);

        // Early last
        push_exp(1'b1, 4'b0011, 32'h0000BBAA);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        idle(2);

        // Back-pressure with a word held
        ready_out = 1'b0;
        push_exp(1'b1, 4'b1111, 32'h0D0C0B0A);
        send_beat(8'h0A, 1'b0);
        send_beat(8'h0B, 1'b0);
        send_beat(8'h0C, 1'b0);
        send_beat(8'h0D, 1'b1);
        push_exp(1'b1, 4'b0001, 32'h000000E1);
        valid_in = 1'b1;
        data_in  = 8'hE1;
        last_in  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {ready_in, valid_out, last_out, keep_out, data_out},
                  {1'b0, 1'b1, 1'b1, 4'b1111, 32'h0D0C0B0A});
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        @(negedge clk);
        check("release_ready_in", ready_in, 1);
        @(posedge clk);
        #1;
        check("same_cycle_accept", {valid_out, last_out, keep_out, data_out},
              {1'b1, 1'b1, 4'b0001, 32'h000000E1});
        idle(2);

        // Streaming, no bubble
        n0 = xfer_cyc.size();
        push_exp(1'b0, 4'b1111, 32'h04030201);
        push_exp(1'b0, 4'b1111, 32'h08070605);
        push_exp(1'b0, 4'b1111, 32'h0C0B0A09);
        for (int i = 1; i <= 12; i++) send_beat(W'(i), 1'b0);
        idle(3);
        check("stream_words", xfer_cyc.size() - n0, 3);
        if (xfer_cyc.size() >= n0 + 3) begin
            check("stream_gap_1", xfer_cyc[n0+1] - xfer_cyc[n0], 4);
            check("stream_gap_2", xfer_cyc[n0+2] - xfer_cyc[n0+1], 4);
        end

        // Async reset with a held word, then with a partial word
        ready_out = 1'b0;
        send_beat(8'hF1, 1'b0);
        send_beat(8'hF2, 1'b0);
        send_beat(8'hF3, 1'b0);
        send_beat(8'hF4, 1'b1);
        check("held_before_rst", {valid_out, data_out}, {1'b1, 32'hF4F3F2F1});
        rst = 1'b1;
        #1;
        check("rst_held_cleared", {valid_out, last_out, keep_out, data_out}, 0);
        idle(1);
        rst       = 1'b0;
        ready_out = 1'b1;
        send_beat(8'h77, 1'b0);
        send_beat(8'h88, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_partial_outputs", {ready_in, valid_out, last_out, keep_out, data_out},
              {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0});
        idle(1);
        rst = 1'b0;
        push_exp(1'b1, 4'b1111, 32'hD4D3D2D1);
        send_beat(8'hD1, 1'b0);
        send_beat(8'hD2, 1'b0);
        send_beat(8'hD3, 1'b0);
        send_beat(8'hD4, 1'b1);
        idle(2);

`ifdef UPSIZE_VR_FLUSH_EN
        // Timeout flush of a one-beat partial word
        push_exp(1'b0, 4'b0001, 32'h0000005A);
        send_beat(8'h5A, 1'b0);
        waited = 0;
        while (!valid_out && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("flush_latency_in_window", (waited >= 16 && waited <= 17), 1);
        idle(2);
`endif

        idle(3);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
